// File: rtl/idma_nd_decomposer.sv
// N-dimensional job to 1-D burst unroller for the iDMA backend.
// Walks an index odometer with running per-dimension address bases.
module idma_nd_decomposer #(
   parameter int unsigned NumDim         = 3,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned LenWidth       = 32,
   parameter int unsigned RepWidth       = 32,
   parameter int unsigned StrideWidth    = 32,
   parameter int unsigned MaxOutstanding = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               nd_req_valid_i,
   output logic                               nd_req_ready_o,
   input  logic [AddrWidth-1:0]               nd_req_src_addr_i,
   input  logic [AddrWidth-1:0]               nd_req_dst_addr_i,
   input  logic [LenWidth-1:0]                nd_req_length_i,
   input  logic [(NumDim-1)*RepWidth-1:0]     nd_req_reps_i,
   input  logic [(NumDim-1)*StrideWidth-1:0]  nd_req_src_strides_i,
   input  logic [(NumDim-1)*StrideWidth-1:0]  nd_req_dst_strides_i,
   output logic                               burst_req_valid_o,
   input  logic                               burst_req_ready_i,
   output logic [AddrWidth-1:0]               burst_req_src_addr_o,
   output logic [AddrWidth-1:0]               burst_req_dst_addr_o,
   output logic [LenWidth-1:0]                burst_req_length_o,
   output logic                               burst_req_last_o,
   input  logic                               burst_rsp_valid_i,
   output logic                               burst_rsp_ready_o,
   input  logic                               burst_rsp_error_i,
   output logic                               nd_rsp_valid_o,
   input  logic                               nd_rsp_ready_i,
   output logic                               nd_rsp_error_o,
   output logic                               busy_o
);
   localparam int unsigned Nd = NumDim - 1;
   localparam int unsigned PW = $clog2(MaxOutstanding + 1);

   localparam logic [1:0] Idle  = 2'd0;
   localparam logic [1:0] Issue = 2'd1;
   localparam logic [1:0] Drain = 2'd2;
   localparam logic [1:0] Resp  = 2'd3;

   logic [1:0]             state;
   logic [AddrWidth-1:0]   sb     [Nd];
   logic [AddrWidth-1:0]   db     [Nd];
   logic [RepWidth-1:0]    reps_q [Nd];
   logic [RepWidth-1:0]    idx    [Nd];
   logic [StrideWidth-1:0] ss_q   [Nd];
   logic [StrideWidth-1:0] ds_q   [Nd];
   logic [LenWidth-1:0]    len_q;
   logic [PW-1:0]          pend;
   logic [PW-1:0]          pend_next;
   logic                   err_q;
   logic [Nd-1:0]          wrap;
   logic [Nd-1:0]          inc;
   logic [Nd-1:0]          clr;
   logic                   any_zero;
   logic [AddrWidth-1:0]   nsrc;
   logic [AddrWidth-1:0]   ndst;
   logic                   req_hs;
   logic                   rsp_hs;

   assign nd_req_ready_o       = state == Idle;
   assign busy_o               = state != Idle;
   assign burst_rsp_ready_o    = (state == Issue) || (state == Drain);
   assign burst_req_valid_o    = (state == Issue) && (pend < PW'(MaxOutstanding));
   assign burst_req_last_o     = (state == Issue) && (&wrap);
   assign burst_req_src_addr_o = sb[0];
   assign burst_req_dst_addr_o = db[0];
   assign burst_req_length_o   = len_q;
   assign nd_rsp_valid_o       = state == Resp;
   assign nd_rsp_error_o       = err_q;

   assign req_hs = burst_req_valid_o && burst_req_ready_i;
   assign rsp_hs = burst_rsp_valid_i && burst_rsp_ready_o && (pend != '0);

   // Odometer carry: the lowest non-wrapping dim steps, all below it restart
   // from that dim's new base.
   always_comb begin
      logic c;
      c        = 1'b1;
      any_zero = 1'b0;
      wrap     = '0;
      inc      = '0;
      clr      = '0;
      nsrc     = sb[0];
      ndst     = db[0];
      for (int k = 0; k < Nd; k++) begin
         any_zero = any_zero | (nd_req_reps_i[k*RepWidth +: RepWidth] == '0);
         wrap[k]  = idx[k] == (reps_q[k] - RepWidth'(1));
         inc[k]   = c & ~wrap[k];
         clr[k]   = c & wrap[k];
         c        = c & wrap[k];
         if (inc[k]) begin
            nsrc = sb[k] + AddrWidth'($signed(ss_q[k]));
            ndst = db[k] + AddrWidth'($signed(ds_q[k]));
         end
      end
   end

   always_comb begin
      pend_next = pend;
      if (req_hs && !rsp_hs) pend_next = pend + PW'(1);
      else if (!req_hs && rsp_hs) pend_next = pend - PW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= Idle;
         len_q <= '0;
         pend  <= '0;
         err_q <= 1'b0;
         for (int k = 0; k < Nd; k++) begin
            sb[k]     <= '0;
            db[k]     <= '0;
            reps_q[k] <= '0;
            idx[k]    <= '0;
            ss_q[k]   <= '0;
            ds_q[k]   <= '0;
         end
      end else begin
         pend <= pend_next;
         if (rsp_hs) err_q <= err_q | burst_rsp_error_i;
         if (req_hs) begin
            for (int k = 0; k < Nd; k++) begin
               if (clr[k]) begin
                  idx[k] <= '0;
                  sb[k]  <= nsrc;
                  db[k]  <= ndst;
               end else if (inc[k]) begin
                  idx[k] <= idx[k] + RepWidth'(1);
                  sb[k]  <= nsrc;
                  db[k]  <= ndst;
               end
            end
         end
         unique case (state)
            Idle: begin
               if (nd_req_valid_i) begin
                  len_q <= nd_req_length_i;
                  pend  <= '0;
                  err_q <= 1'b0;
                  for (int k = 0; k < Nd; k++) begin
                     sb[k]     <= nd_req_src_addr_i;
                     db[k]     <= nd_req_dst_addr_i;
                     idx[k]    <= '0;
                     reps_q[k] <= nd_req_reps_i[k*RepWidth +: RepWidth];
                     ss_q[k]   <= nd_req_src_strides_i[k*StrideWidth +: StrideWidth];
                     ds_q[k]   <= nd_req_dst_strides_i[k*StrideWidth +: StrideWidth];
                  end
                  state <= any_zero ? Resp : Issue;
               end
            end
            Issue: if (req_hs && (&wrap)) state <= Drain;
            Drain: if (pend_next == '0) state <= Resp;
            Resp:  if (nd_rsp_ready_i) state <= Idle;
            default: state <= Idle;
         endcase
      end
   end

   // Responses are only legal against an outstanding burst.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!burst_rsp_valid_i || (burst_rsp_ready_o && (pend != '0)));
      end
   end

endmodule
